// File: rtl/fp16_tensor_serializer.sv
// fp16_tensor_serializer
// Latches a flattened FP16 feature map on an accepted start pulse and streams it
// out one element per valid/ready handshake, tagged with channel/row/column.
// Element i sits at Input_Tensor[i*DATA_WIDTH +: DATA_WIDTH], i = ch*H*W + row*W + col.
// Optional build macro: RELU_INLINE_EN -- when defined, elements whose sign bit is
// set are presented as zero; when undefined, elements pass through bit-exact.

module fp16_tensor_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 10,
  parameter int W          = 10,
  parameter int CHANNEL    = 16,
  localparam int N  = H * W * CHANNEL,
  localparam int CW = (CHANNEL > 1) ? $clog2(CHANNEL) : 1,
  localparam int RW = (H > 1) ? $clog2(H) : 1,
  localparam int XW = (W > 1) ? $clog2(W) : 1,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] Input_Tensor,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CW-1:0]           out_ch,
  output logic [RW-1:0]           out_row,
  output logic [XW-1:0]           out_col,
  output logic                    out_last,
  output logic                    done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] cap_q [N];
  logic [IW-1:0]         idx_q;
  logic [CW-1:0]         ch_q;
  logic [RW-1:0]         row_q;
  logic [XW-1:0]         col_q;
  logic                  busy_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  done_q;

  logic [IW-1:0]         idx_d;
  logic [IW-1:0]         rd_idx_d;
  logic [CW-1:0]         ch_d;
  logic [RW-1:0]         row_d;
  logic [XW-1:0]         col_d;
  logic                  start_acc_d;
  logic                  handshake_d;

  // Optional inline ReLU clamp: negative-signed elements (including -0 and
  // negative NaN) become +0 when enabled.
  function automatic logic [DATA_WIDTH-1:0] clamp_f(input logic [DATA_WIDTH-1:0] elem);
`ifdef RELU_INLINE_EN
    if (elem[DATA_WIDTH-1]) begin
      clamp_f = {DATA_WIDTH{1'b0}};
    end else begin
      clamp_f = elem;
    end
`else
    clamp_f = elem;
`endif
  endfunction

  assign start_acc_d = (state_q == S_IDLE) && start;
  assign handshake_d = (state_q == S_STREAM) && out_valid_q && out_ready;

  // Next element index and tags: col wraps into row, row wraps into channel.
  always_comb begin
    idx_d = idx_q + {{(IW-1){1'b0}}, 1'b1};
    ch_d  = ch_q;
    row_d = row_q;
    col_d = col_q;
    if (col_q == XW'(W - 1)) begin
      col_d = {XW{1'b0}};
      if (row_q == RW'(H - 1)) begin
        row_d = {RW{1'b0}};
        ch_d  = ch_q + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        row_d = row_q + {{(RW-1){1'b0}}, 1'b1};
      end
    end else begin
      col_d = col_q + {{(XW-1){1'b0}}, 1'b1};
    end
    // Keep the read address in range once the final element is on the bus.
    if (out_last_q) begin
      rd_idx_d = {IW{1'b0}};
    end else begin
      rd_idx_d = idx_d;
    end
  end

  // Capture store: written only on an accepted start, so a start while busy
  // or later changes on Input_Tensor cannot disturb an ongoing stream.
  always_ff @(posedge clk) begin
    if (start_acc_d) begin
      for (int k = 0; k < N; k++) begin
        cap_q[k] <= Input_Tensor[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control FSM with all outputs registered; element 0 comes straight from the
  // input bus so it is presented the cycle after start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= {IW{1'b0}};
      ch_q        <= {CW{1'b0}};
      row_q       <= {RW{1'b0}};
      col_q       <= {XW{1'b0}};
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q     <= S_STREAM;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b1;
            idx_q       <= {IW{1'b0}};
            ch_q        <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            col_q       <= {XW{1'b0}};
            out_data_q  <= clamp_f(Input_Tensor[DATA_WIDTH-1:0]);
            out_last_q  <= (N == 1);
          end else begin
            // busy lingers one cycle past the done pulse, dropping here.
            busy_q <= 1'b0;
          end
        end
        S_STREAM: begin
          if (handshake_d) begin
            if (out_last_q) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q      <= idx_d;
              ch_q       <= ch_d;
              row_q      <= row_d;
              col_q      <= col_d;
              out_data_q <= clamp_f(cap_q[rd_idx_d]);
              out_last_q <= (idx_d == IW'(N - 1));
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = ch_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fp16_tensor_serializer.sv
// Testbench for fp16_tensor_serializer: default-size instance streamed against a
// queue/array reference model, plus a 1x1x1 instance for the single-beat case.
module tb_fp16_tensor_serializer;

  localparam int DW = 16;
  localparam int H  = 10;
  localparam int W  = 10;
  localparam int C  = 16;
  localparam int N  = H * W * C;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N*DW-1:0] tensor_in;
  logic          busy, out_valid, out_ready, out_last, done;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ch, out_row, out_col;

  logic          sm_start, sm_busy, sm_valid, sm_ready, sm_last, sm_done;
  logic [DW-1:0] sm_tensor, sm_data;
  logic          sm_ch, sm_row, sm_col;

  int checks;
  int failures;

  logic [DW-1:0] model_mem [N];
  logic [DW-1:0] seen_data [N];

  typedef struct {
    logic [DW-1:0] din;
    logic [DW-1:0] exp_relu;
    logic [DW-1:0] exp_pass;
  } vec_t;
  vec_t vecs [8];

  fp16_tensor_serializer #(.DATA_WIDTH(DW), .H(H), .W(W), .CHANNEL(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Input_Tensor(tensor_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .done(done)
  );

  fp16_tensor_serializer #(.DATA_WIDTH(DW), .H(1), .W(1), .CHANNEL(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(sm_start), .Input_Tensor(sm_tensor),
    .busy(sm_busy), .out_valid(sm_valid), .out_ready(sm_ready), .out_data(sm_data),
    .out_ch(sm_ch), .out_row(sm_row), .out_col(sm_col), .out_last(sm_last),
    .done(sm_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
`ifdef RELU_INLINE_EN
    return (x >= 16'h8000) ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tensor();
    for (int i = 0; i < N; i++) tensor_in[i*DW +: DW] = model_mem[i];
  endtask

  task automatic pulse_start();
    load_tensor();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Consume beats, comparing each accepted beat with the model element k.
  task automatic run_stream(input bit rnd, input int inject_at, input int abort_at,
                            output int cycles);
    int k;
    int cyc;
    bit injected;
    k = 0;
    cyc = 0;
    injected = 1'b0;
    while (k < N && cyc < 8 * N && k != abort_at) begin
      if (!injected && k == inject_at) begin
        start = 1'b1;
        tensor_in = '1;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      chk("valid_held", {31'd0, out_valid}, 32'd1);
      if (out_valid && out_ready) begin
        seen_data[k] = out_data;
        chk("data", {16'd0, out_data}, {16'd0, relu_ref(model_mem[k])});
        chk("ch", {28'd0, out_ch}, k / (H * W));
        chk("row", {28'd0, out_row}, (k / W) % H);
        chk("col", {28'd0, out_col}, k % W);
        chk("last", {31'd0, out_last}, (k == N - 1) ? 32'd1 : 32'd0);
        chk("busy_stream", {31'd0, busy}, 32'd1);
        k++;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    cycles = cyc;
    if (k != abort_at) chk("beats_delivered", k, N);
  endtask

  // Tail after the final handshake: done pulse, then busy drops a cycle later.
  task automatic finish_check();
    chk("tail_valid", {31'd0, out_valid}, 32'd0);
    chk("tail_done", {31'd0, done}, 32'd1);
    chk("tail_busy", {31'd0, busy}, 32'd1);
    step();
    chk("tail_done_pulse", {31'd0, done}, 32'd0);
    chk("tail_busy2", {31'd0, busy}, 32'd1);
    chk("tail_valid2", {31'd0, out_valid}, 32'd0);
    step();
    chk("tail_busy_low", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    checks = 0;
    failures = 0;
    vecs[0] = '{16'hBC00, 16'h0000, 16'hBC00};
    vecs[1] = '{16'h8000, 16'h0000, 16'h8000};
    vecs[2] = '{16'h3C00, 16'h3C00, 16'h3C00};
    vecs[3] = '{16'h7C00, 16'h7C00, 16'h7C00};
    vecs[4] = '{16'hFE00, 16'h0000, 16'hFE00};
    vecs[5] = '{16'h7E00, 16'h7E00, 16'h7E00};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{16'hFFFF, 16'h0000, 16'hFFFF};

    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    tensor_in = '0;
    sm_start = 1'b0;
    sm_ready = 1'b0;
    sm_tensor = 16'h0000;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_tags", {20'd0, out_ch, out_row, out_col}, 32'd0);

    // Test 1: counting tensor, ready held high, back-to-back beats.
    for (int i = 0; i < N; i++) model_mem[i] = 16'(i);
    pulse_start();
    run_stream(1'b0, -1, -1, cyc);
    chk("no_bubbles_cycles", cyc, N);
    finish_check();

    // Test 2: same tensor, random back-pressure.
    pulse_start();
    run_stream(1'b1, -1, -1, cyc);
    finish_check();

    // Test 3: start mid-stream with an all-ones tensor must be ignored.
    pulse_start();
    run_stream(1'b0, 300, -1, cyc);
    finish_check();
    for (int i = 0; i < N; i++) model_mem[i] = 16'hFFFF;
    pulse_start();
    run_stream(1'b0, -1, -1, cyc);
    finish_check();

    // Test 4: asynchronous reset at beat 500, then a clean restart.
    for (int i = 0; i < N; i++) model_mem[i] = 16'($urandom);
    pulse_start();
    run_stream(1'b0, -1, 500, cyc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_data", {16'd0, out_data}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Test 5: table vectors in the first elements, random remainder and ready.
    for (int i = 0; i < N; i++) model_mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) model_mem[i] = vecs[i].din;
    pulse_start();
    chk("restart_tags", {20'd0, out_ch, out_row, out_col}, 32'd0);
    run_stream(1'b1, -1, -1, cyc);
    finish_check();
    for (int i = 0; i < 8; i++) begin
`ifdef RELU_INLINE_EN
      chk("relu_table", {16'd0, seen_data[i]}, {16'd0, vecs[i].exp_relu});
`else
      chk("pass_table", {16'd0, seen_data[i]}, {16'd0, vecs[i].exp_pass});
`endif
    end

    // Test 6: 1x1x1 instance -- single beat, done next cycle, busy three cycles.
    sm_tensor = 16'h4A5B;
    sm_ready = 1'b1;
    sm_start = 1'b1;
    step();
    sm_start = 1'b0;
    sm_tensor = 16'h0000;
    chk("sm_valid", {31'd0, sm_valid}, 32'd1);
    chk("sm_last", {31'd0, sm_last}, 32'd1);
    chk("sm_data", {16'd0, sm_data}, 32'h4A5B);
    chk("sm_tags", {29'd0, sm_ch, sm_row, sm_col}, 32'd0);
    chk("sm_busy1", {31'd0, sm_busy}, 32'd1);
    chk("sm_done0", {31'd0, sm_done}, 32'd0);
    step();
    chk("sm_valid_drop", {31'd0, sm_valid}, 32'd0);
    chk("sm_done", {31'd0, sm_done}, 32'd1);
    chk("sm_busy2", {31'd0, sm_busy}, 32'd1);
    sm_start = 1'b1;
    step();
    sm_start = 1'b0;
    chk("sm_start_in_done_ignored", {31'd0, sm_valid}, 32'd0);
    chk("sm_done_pulse", {31'd0, sm_done}, 32'd0);
    chk("sm_busy3", {31'd0, sm_busy}, 32'd1);
    step();
    chk("sm_busy_low", {31'd0, sm_busy}, 32'd0);
    chk("sm_valid_idle", {31'd0, sm_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
